// File: rtl/i2c_rx_sequencer_if.sv
// i2c_rx_sequencer_if: SCL/SDA strobes, byte-shifter commands and the downstream byte handshake.
interface i2c_rx_sequencer_if;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda_in;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;
  logic       rx_shift;
  logic       rx_bit;
  logic       rx_clear;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_accept;
  logic       sda_drive_low;
  logic       busy;
  modport slave (
    input  scl_rise, scl_fall, sda_in, start_det, stop_det, rx_byte, data_accept,
    output rx_shift, rx_bit, rx_clear, data_out, data_valid, sda_drive_low, busy
  );
  modport master (
    output scl_rise, scl_fall, sda_in, start_det, stop_det, rx_byte, data_accept,
    input  rx_shift, rx_bit, rx_clear, data_out, data_valid, sda_drive_low, busy
  );
endinterface

// File: rtl/i2c_rx_sequencer.sv
// i2c_rx_sequencer: write-only I2C target sequencer driving an external byte shifter.
module i2c_rx_sequencer #(
  parameter logic [6:0] ADDRESS = 7'h2A
) (
  input logic clk,
  input logic rst_n,
  i2c_rx_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       shift_q, shift_d, bit_q, bit_d, clear_q, clear_d, dec_q, dec_d;
  logic       ack_q, ack_d, slot_q, slot_d, sda_q, sda_d, dv_q, dv_d;
  logic [7:0] dout_q, dout_d;
  logic       ack_now;
  assign ack_now = (state_q == ADDR) ? (bus.rx_byte[7:1] == ADDRESS && !bus.rx_byte[0]) : bus.data_accept;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      bit_q   <= 1'b0;
      clear_q <= 1'b0;
      dec_q   <= 1'b0;
      ack_q   <= 1'b0;
      slot_q  <= 1'b0;
      sda_q   <= 1'b0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      clear_q <= clear_d;
      dec_q   <= dec_d;
      ack_q   <= ack_d;
      slot_q  <= slot_d;
      sda_q   <= sda_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = 1'b0;
    bit_d   = bit_q;
    clear_d = 1'b0;
    dec_d   = 1'b0;
    ack_d   = ack_q;
    slot_d  = slot_q;
    sda_d   = sda_q;
    dv_d    = 1'b0;
    dout_d  = dout_q;
    if (bus.start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      clear_d = 1'b1;
      sda_d   = 1'b0;
      slot_d  = 1'b0;
    end else if (bus.stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b0;
      slot_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (bus.scl_rise) begin
            shift_d = 1'b1;
            bit_d   = bus.sda_in;
            cnt_d   = cnt_q + 3'd1;
          end
          // counter has just wrapped: the byte is complete once this shift lands
          dec_d = shift_q && cnt_q == 3'd0;
          if (dec_q) begin
            ack_d   = ack_now;
            slot_d  = 1'b0;
            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
            dv_d    = state_q == DATA && ack_now;
            dout_d  = (state_q == DATA && ack_now) ? bus.rx_byte : dout_q;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (bus.scl_fall) begin
            sda_d   = slot_q ? 1'b0 : ack_q;
            slot_d  = !slot_q;
            clear_d = slot_q;
            cnt_d   = slot_q ? 3'd0 : cnt_q;
            state_d = slot_q ? (ack_q ? DATA : IGNORE) : state_q;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.rx_shift      = shift_q;
  assign bus.rx_bit        = shift_q & bit_q;
  assign bus.rx_clear      = clear_q;
  assign bus.data_out      = dout_q;
  assign bus.data_valid    = dv_q;
  assign bus.sda_drive_low = sda_q;
  assign bus.busy          = state_q != IDLE;
endmodule

// File: tb/tb_i2c_rx_sequencer.sv
// tb_i2c_rx_sequencer: directed bench with a behavioural MSB-first shifter model.
module tb_i2c_rx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  int n_dv = 0;
  int n_shift = 0;
  int n_clear = 0;
  logic [7:0] last_do = '0;
  i2c_rx_sequencer_if bus();
  i2c_rx_sequencer #(.ADDRESS(7'h2A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!rst_n || bus.rx_clear) bus.rx_byte <= '0;
    else if (bus.rx_shift) bus.rx_byte <= {bus.rx_byte[6:0], bus.rx_bit};
  always @(negedge clk) begin
    if (bus.data_valid) begin
      n_dv++;
      last_do = bus.data_out;
    end
    if (bus.rx_shift) n_shift++;
    if (bus.rx_clear) n_clear++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start_det = 1'b1;
    cyc(1);
    bus.start_det = 1'b0;
    cyc(2);
  endtask
  task automatic rise_fall();
    bus.scl_rise = 1'b1;
    cyc(1);
    bus.scl_rise = 1'b0;
    cyc(4);
    bus.scl_fall = 1'b1;
    cyc(1);
    bus.scl_fall = 1'b0;
    cyc(2);
  endtask
  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.sda_in = b[i];
      cyc(1);
      rise_fall();
    end
  endtask
  task automatic xfer(input logic [7:0] b, output logic a8, output logic a9, output logic rel);
    bits(b, 8);
    a8 = bus.sda_drive_low;
    bus.scl_rise = 1'b1;
    cyc(1);
    bus.scl_rise = 1'b0;
    cyc(4);
    a9 = bus.sda_drive_low;
    bus.scl_fall = 1'b1;
    cyc(1);
    bus.scl_fall = 1'b0;
    cyc(2);
    rel = bus.sda_drive_low;
  endtask
  initial begin
    int dv0, sh0, cl0;
    logic a8, a9, rel;
    bus.scl_rise = 0; bus.scl_fall = 0; bus.sda_in = 1; bus.start_det = 0;
    bus.stop_det = 0; bus.data_accept = 1;
    cyc(3);
    check("rst_outs", {bus.rx_shift, bus.rx_bit, bus.rx_clear, bus.data_valid, bus.sda_drive_low, bus.busy}, 0);
    check("rst_dout", bus.data_out, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    check("idle_busy", bus.busy, 0);
    // address write ACK
    cl0 = n_clear;
    pulse_start();
    check("start_busy", bus.busy, 1);
    check("start_clr", n_clear - cl0, 1);
    dv0 = n_dv; sh0 = n_shift; cl0 = n_clear;
    xfer(8'h54, a8, a9, rel);
    check("addr_ack8", a8, 1);
    check("addr_ack9", a9, 1);
    check("addr_rel", rel, 0);
    check("addr_shifts", n_shift - sh0, 8);
    check("addr_clr", n_clear - cl0, 1);
    check("addr_nodv", n_dv - dv0, 0);
    // two data bytes
    dv0 = n_dv; cl0 = n_clear;
    xfer(8'hA5, a8, a9, rel);
    check("dA5_ack", a8, 1);
    check("dA5_dv", n_dv - dv0, 1);
    check("dA5_out", last_do, 8'hA5);
    xfer(8'h3C, a8, a9, rel);
    check("d3C_ack", a8, 1);
    check("d3C_rel", rel, 0);
    check("d3C_dv", n_dv - dv0, 2);
    check("d3C_out", last_do, 8'h3C);
    check("data_clr", n_clear - cl0, 2);
    // wrong address, then read request
    pulse_start();
    xfer(8'h56, a8, a9, rel);
    check("wrong_nack", {a8, a9}, 0);
    dv0 = n_dv; sh0 = n_shift;
    xfer(8'h11, a8, a9, rel);
    check("ign_shift", n_shift - sh0, 0);
    check("ign_dv", n_dv - dv0, 0);
    check("ign_sda", {a8, a9, rel}, 0);
    check("ign_busy", bus.busy, 1);
    pulse_start();
    xfer(8'h55, a8, a9, rel);
    check("read_nack", {a8, a9}, 0);
    sh0 = n_shift;
    xfer(8'hFF, a8, a9, rel);
    check("read_ign", n_shift - sh0, 0);
    // backpressure
    pulse_start();
    xfer(8'h54, a8, a9, rel);
    check("bp_addr", a8, 1);
    bus.data_accept = 0;
    dv0 = n_dv;
    xfer(8'h77, a8, a9, rel);
    check("bp_nack", {a8, a9}, 0);
    check("bp_nodv", n_dv - dv0, 0);
    bus.data_accept = 1;
    sh0 = n_shift;
    xfer(8'h12, a8, a9, rel);
    check("bp_ign", n_shift - sh0 + n_dv - dv0, 0);
    pulse_start();
    xfer(8'h54, a8, a9, rel);
    xfer(8'h99, a8, a9, rel);
    check("bp_reack", a8, 1);
    check("bp_redv", n_dv - dv0, 1);
    check("bp_out", last_do, 8'h99);
    // STOP after four data bits
    dv0 = n_dv;
    bits(8'hF0, 4);
    bus.stop_det = 1'b1;
    cyc(1);
    bus.stop_det = 1'b0;
    cyc(2);
    check("stop_busy", bus.busy, 0);
    check("stop_nodv", n_dv - dv0, 0);
    sh0 = n_shift;
    bits(8'hFF, 2);
    check("idle_noshift", n_shift - sh0, 0);
    // repeated START after three address bits
    pulse_start();
    bits(8'h54, 3);
    cl0 = n_clear;
    pulse_start();
    check("rs_clr", n_clear - cl0, 1);
    xfer(8'h54, a8, a9, rel);
    check("rs_ack", a8, 1);
    // START coinciding with scl_rise
    pulse_start();
    sh0 = n_shift; cl0 = n_clear;
    bus.sda_in = 1'b1;
    bus.start_det = 1'b1;
    bus.scl_rise = 1'b1;
    cyc(1);
    bus.start_det = 1'b0;
    bus.scl_rise = 1'b0;
    cyc(3);
    check("sr_noshift", n_shift - sh0, 0);
    check("sr_clr", n_clear - cl0, 1);
    xfer(8'h54, a8, a9, rel);
    check("sr_ack", a8, 1);
    // reset during the ACK slot
    pulse_start();
    bits(8'h54, 8);
    check("rst_pre_sda", bus.sda_drive_low, 1);
    rst_n = 1'b0;
    cyc(1);
    check("rst_ack_outs", {bus.rx_shift, bus.rx_clear, bus.data_valid, bus.sda_drive_low, bus.busy}, 0);
    check("rst_ack_dout", bus.data_out, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    check("rst_ack_idle", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
